// File: rtl/cfu_pkg.sv
// Shared definitions for the vector CFU front-end and decoder_block:
// opcode values, bus widths and the sequencer FSM state encoding.
package cfu_pkg;

   localparam int FUNC_ID_W = 10;
   localparam int DATA_W    = 32;
   localparam int OP_W      = 5;

   localparam logic [OP_W-1:0] OP_VSETVLI = 5'h17;
   localparam logic [OP_W-1:0] OP_VLOAD   = 5'h07;
   localparam logic [OP_W-1:0] OP_VADDI   = 5'h15;
   localparam logic [OP_W-1:0] OP_VACC    = 5'h0D;
   localparam logic [OP_W-1:0] OP_VMUL    = 5'h04;
   localparam logic [OP_W-1:0] OP_VBACC   = 5'h1D;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUSY,
      ST_RESP
   } state_t;

   function automatic logic op_known(input logic [OP_W-1:0] op);
      return op inside {OP_VSETVLI, OP_VLOAD, OP_VADDI,
                        OP_VACC, OP_VMUL, OP_VBACC};
   endfunction

endpackage

// File: rtl/cfu_op_latency.sv
// Combinational opcode -> execution latency (cycles, counted from issue).
// Ports: opcode (in), lat (out, CNT_W bits, always >= 1).
module cfu_op_latency
   import cfu_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int ACC_LAT = 2,
   parameter int CNT_W   = 2
) (
   input  logic [OP_W-1:0]  opcode,
   output logic [CNT_W-1:0] lat
);

   always_comb begin
      lat = CNT_W'(1);
      case (opcode)
         OP_VMUL:           lat = CNT_W'(MUL_LAT);
         OP_VACC, OP_VBACC: lat = CNT_W'(ACC_LAT);
         default:           lat = CNT_W'(1);
      endcase
   end

endmodule

// File: rtl/cfu_cmd_sequencer.sv
// CFU front-end: accepts one CPU command, strobes it to the decoder for one
// cycle, waits the opcode latency, then returns a response; owns vl.
// Ports: clk/reset; cmd_* handshake + payload in; rsp_* handshake + data out;
// dec_* registered command to decoder; dp_result datapath result in; vl out.
module cfu_cmd_sequencer
   import cfu_pkg::*;
#(
   parameter int VLMAX   = 16,
   parameter int MUL_LAT = 3,
   parameter int ACC_LAT = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [FUNC_ID_W-1:0]       cmd_payload_function_id,
   input  logic [DATA_W-1:0]          cmd_payload_inputs_0,
   input  logic [DATA_W-1:0]          cmd_payload_inputs_1,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_W-1:0]          rsp_payload_outputs_0,
   output logic                       dec_valid,
   output logic [FUNC_ID_W-1:0]       dec_function_id,
   output logic [DATA_W-1:0]          dec_inputs_0,
   output logic [DATA_W-1:0]          dec_inputs_1,
   input  logic [DATA_W-1:0]          dp_result,
   output logic [$clog2(VLMAX+1)-1:0] vl
);

   localparam int VL_W    = $clog2(VLMAX+1);
   localparam int LAT_MAX = (MUL_LAT > ACC_LAT) ? MUL_LAT : ACC_LAT;
   localparam int CNT_W   = $clog2(LAT_MAX+1);

   if (MUL_LAT < 1 || ACC_LAT < 1 || VLMAX < 1) begin : g_bad_param
      $fatal(1, "cfu_cmd_sequencer: MUL_LAT, ACC_LAT, VLMAX must be >= 1");
   end

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  lat;
   logic [OP_W-1:0]   op;
   logic [VL_W-1:0]   vl_new;
   logic              last;
   logic              accept;
   logic              capture;

   cfu_op_latency #(
      .MUL_LAT (MUL_LAT),
      .ACC_LAT (ACC_LAT),
      .CNT_W   (CNT_W)
   ) u_lat (
      .opcode (cmd_payload_function_id[FUNC_ID_W-1 -: OP_W]),
      .lat    (lat)
   );

   assign op   = dec_function_id[FUNC_ID_W-1 -: OP_W];
   assign last = (cnt_q == CNT_W'(1));

   // Full-width unsigned clamp so huge rs1 values saturate to VLMAX.
   assign vl_new = (dec_inputs_0 > DATA_W'(VLMAX)) ? VL_W'(VLMAX)
                                                   : dec_inputs_0[VL_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      dec_valid = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Issue is latency cycle 1, so L=1 captures right here.
            dec_valid = 1'b1;
            if (last) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (last) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q                 <= '0;
         dec_function_id       <= '0;
         dec_inputs_0          <= '0;
         dec_inputs_1          <= '0;
         vl                    <= '0;
         rsp_payload_outputs_0 <= '0;
      end else begin
         if (accept) begin
            dec_function_id <= cmd_payload_function_id;
            dec_inputs_0    <= cmd_payload_inputs_0;
            dec_inputs_1    <= cmd_payload_inputs_1;
            cnt_q           <= lat;
         end else if ((state_q == ST_ISSUE || state_q == ST_BUSY) && !last) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (dec_valid && op == OP_VSETVLI) vl <= vl_new;
         if (capture) begin
            if (op == OP_VSETVLI)  rsp_payload_outputs_0 <= DATA_W'(vl_new);
            else if (op_known(op)) rsp_payload_outputs_0 <= dp_result;
            else                   rsp_payload_outputs_0 <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Self-checking bench for cfu_cmd_sequencer: directed vector table,
// hand-written reset/backpressure sequences, randomized model comparison.
module tb_cfu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;
   logic        dec_valid;
   logic [9:0]  dec_function_id;
   logic [31:0] dec_inputs_0;
   logic [31:0] dec_inputs_1;
   logic [31:0] dp_result;
   logic [4:0]  vl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cfu_cmd_sequencer #(
      .VLMAX   (16),
      .MUL_LAT (3),
      .ACC_LAT (2)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (cmd_payload_function_id),
      .cmd_payload_inputs_0    (cmd_payload_inputs_0),
      .cmd_payload_inputs_1    (cmd_payload_inputs_1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_payload_outputs_0),
      .dec_valid               (dec_valid),
      .dec_function_id         (dec_function_id),
      .dec_inputs_0            (dec_inputs_0),
      .dec_inputs_1            (dec_inputs_1),
      .dp_result               (dp_result),
      .vl                      (vl)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: latency and response data straight from the opcode table.
   function automatic int ref_lat(input logic [4:0] op);
      case (op)
         5'h04:        return 3;
         5'h0D, 5'h1D: return 2;
         default:      return 1;
      endcase
   endfunction

   function automatic logic [31:0] ref_clamp(input logic [31:0] in0);
      return (in0 > 32'd16) ? 32'd16 : in0;
   endfunction

   function automatic logic [31:0] ref_data(input logic [4:0] op,
                                            input logic [31:0] in0,
                                            input logic [31:0] dp);
      if (op == 5'h17) return ref_clamp(in0);
      if (op inside {5'h07, 5'h15, 5'h0D, 5'h04, 5'h1D}) return dp;
      return 32'h0;
   endfunction

   // Entered and left at a negedge while the DUT is idle.
   task automatic run_cmd(input logic [4:0] op, input logic [31:0] in0,
                          input logic [31:0] dp, input int stall,
                          input bit hold_next, input logic [31:0] exp_data,
                          input int exp_lat, input logic [4:0] exp_vl);
      int  k;
      bit  seen;
      logic [9:0] fid;
      fid = {op, 5'($urandom_range(0, 31))};
      chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
      cmd_valid               = 1'b1;
      cmd_payload_function_id = fid;
      cmd_payload_inputs_0    = in0;
      cmd_payload_inputs_1    = $urandom;
      rsp_ready               = (stall == 0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      seen = 1'b0;
      k = 1;
      while (!seen && k <= 20) begin
         dp_result = (k == exp_lat) ? dp : $urandom;
         @(negedge clk);
         chk("dec_valid_pulse", {31'b0, dec_valid}, (k == 1) ? 32'd1 : 32'd0);
         if (rsp_valid) begin
            seen = 1'b1;
            chk("latency", k - 1, exp_lat);
         end else begin
            chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1;
            k++;
         end
      end
      if (!seen) begin
         chk("rsp_timeout", 32'd0, 32'd1);
         @(negedge clk);
         return;
      end
      for (int s = 0; s < stall; s++) begin
         chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("stall_data", rsp_payload_outputs_0, exp_data);
         chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         if (hold_next) begin
            cmd_valid               = 1'b1;
            cmd_payload_function_id = {5'h07, 5'd1};
            cmd_payload_inputs_0    = 32'h77;
         end
         @(posedge clk);
         #1;
         dp_result = $urandom;
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      chk("rsp_data", rsp_payload_outputs_0, exp_data);
      chk("rsp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("dec_fid_hold", {22'b0, dec_function_id}, {22'b0, fid});
      chk("dec_in0_hold", dec_inputs_0, in0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_done", {31'b0, rsp_valid}, 32'd0);
      chk("cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
      chk("vl", {27'b0, vl}, {27'b0, exp_vl});
      if (hold_next) begin
         chk("held_not_accepted", {31'b0, dec_valid}, 32'd0);
         chk("held_fid_old", {22'b0, dec_function_id}, {22'b0, fid});
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] in0;
      logic [31:0] dp;
      int          stall;
      logic [31:0] exp_data;
      int          exp_lat;
      logic [4:0]  exp_vl;
   } vec_t;

   vec_t vec[13];
   logic [4:0] mvl;

   initial begin
      vec[0]  = '{5'h17, 32'd9,          32'h5555, 0, 32'd9,         1, 5'd9};
      vec[1]  = '{5'h04, 32'd1,          32'hDEADBEEF, 0, 32'hDEADBEEF, 3, 5'd9};
      vec[2]  = '{5'h07, 32'd2,          32'h11111111, 0, 32'h11111111, 1, 5'd9};
      vec[3]  = '{5'h0D, 32'd3,          32'h22222222, 0, 32'h22222222, 2, 5'd9};
      vec[4]  = '{5'h15, 32'd4,          32'h33333333, 0, 32'h33333333, 1, 5'd9};
      vec[5]  = '{5'h1F, 32'd5,          32'hAAAA, 0, 32'h0,           1, 5'd9};
      vec[6]  = '{5'h1D, 32'd6,          32'h44, 1, 32'h44,            2, 5'd9};
      vec[7]  = '{5'h17, 32'hFFFFFFFF,   32'h1, 0, 32'd16,             1, 5'd16};
      vec[8]  = '{5'h17, 32'd17,         32'h1, 0, 32'd16,             1, 5'd16};
      vec[9]  = '{5'h17, 32'd16,         32'h1, 0, 32'd16,             1, 5'd16};
      vec[10] = '{5'h17, 32'd0,          32'h1, 0, 32'd0,              1, 5'd0};
      vec[11] = '{5'h17, 32'h80000003,   32'h1, 2, 32'd16,             1, 5'd16};
      vec[12] = '{5'h17, 32'd9,          32'h1, 3, 32'd9,              1, 5'd9};

      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_payload_function_id = '0;
      cmd_payload_inputs_0 = '0;
      cmd_payload_inputs_1 = '0;
      rsp_ready = 1'b0;
      dp_result = '0;
      #1;
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
      chk("rst_out", rsp_payload_outputs_0, 32'd0);
      chk("rst_vl", {27'b0, vl}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      foreach (vec[i])
         run_cmd(vec[i].op, vec[i].in0, vec[i].dp, vec[i].stall, 1'b0,
                 vec[i].exp_data, vec[i].exp_lat, vec[i].exp_vl);

      // Backpressure with a second command held valid throughout.
      run_cmd(5'h04, 32'd1, 32'hCAFEF00D, 5, 1'b1, 32'hCAFEF00D, 3, 5'd9);
      run_cmd(5'h07, 32'h77, 32'h600D, 0, 1'b0, 32'h600D, 1, 5'd9);

      // Reset while vmul is busy.
      cmd_valid = 1'b1;
      cmd_payload_function_id = {5'h04, 5'd3};
      cmd_payload_inputs_0 = 32'h1234;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("mid_rst_vl", {27'b0, vl}, 32'd0);
      chk("mid_rst_dec_in0", dec_inputs_0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
      end
      rsp_ready = 1'b0;

      // Randomized commands against the reference model.
      mvl = 5'd0;
      for (int n = 0; n < 60; n++) begin
         logic [4:0]  rop;
         logic [31:0] rin0;
         logic [31:0] rdp;
         logic [4:0]  ops[7];
         ops = '{5'h17, 5'h07, 5'h15, 5'h0D, 5'h04, 5'h1D, 5'h00};
         rop  = ops[$urandom_range(0, 6)];
         if (rop == 5'h00) rop = 5'($urandom);
         rin0 = $urandom_range(0, 1) ? 32'($urandom_range(0, 20)) : $urandom;
         rdp  = $urandom;
         if (rop == 5'h17) mvl = 5'(ref_clamp(rin0));
         run_cmd(rop, rin0, rdp, $urandom_range(0, 3), 1'b0,
                 ref_data(rop, rin0, rdp), ref_lat(rop), mvl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
